// File: rtl/irq_pkg.sv
// Shared types and helpers for the interrupt request capture stage.
package irq_pkg;

    localparam int REQ_W = 8;
    localparam int IDX_W = 3;

    typedef enum logic {
        IDLE    = 1'b0,
        PRESENT = 1'b1
    } state_t;

    function automatic logic [REQ_W-1:0] onehot8(input logic [IDX_W-1:0] idx);
        logic [REQ_W-1:0] vec;
        vec      = '0;
        vec[idx] = 1'b1;
        return vec;
    endfunction

endpackage

// File: rtl/prio_enc8.sv
// Combinational 8-to-3 priority encoder; the highest set bit wins, index 0 when empty.
module prio_enc8
    import irq_pkg::*;
(
    input  logic [REQ_W-1:0] eligible,
    output logic [IDX_W-1:0] index,
    output logic             any_valid
);

    always_comb begin
        index = '0;
        for (int i = 0; i < REQ_W; i++) begin
            if (eligible[i]) begin
                index = IDX_W'(i);
            end
        end
    end

    assign any_valid = |eligible;

endmodule

// File: rtl/irq_req_capture.sv
// Synchronises request lines, latches them as pending events and presents
// the highest-priority masked pending index over a valid/ack handshake.
module irq_req_capture
    import irq_pkg::*;
#(
    parameter int EDGE_MODE   = 1,
    parameter int SYNC_STAGES = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [7:0]   req_in,
    input  logic [7:0]   mask,
    input  logic         irq_ack,
    input  logic         ovf_clr,
    output logic         irq_valid,
    output logic [2:0]   irq_idx,
    output logic [7:0]   pending,
    output logic [7:0]   overflow
);

    logic [REQ_W-1:0] sync_q [SYNC_STAGES];
    logic [REQ_W-1:0] req_s;
    logic [REQ_W-1:0] req_d;
    logic [REQ_W-1:0] set_vec;
    logic [REQ_W-1:0] clr_vec;
    logic [REQ_W-1:0] pending_q;
    logic [REQ_W-1:0] overflow_q;
    logic [REQ_W-1:0] eligible;
    logic [IDX_W-1:0] enc_idx;
    logic             enc_any;
    logic [IDX_W-1:0] idx_q, idx_d;
    state_t           state_q, state_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
            req_d <= '0;
        end else begin
            sync_q[0] <= req_in;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
            req_d <= req_s;
        end
    end

    assign req_s   = sync_q[SYNC_STAGES-1];
    assign set_vec = (EDGE_MODE != 0) ? (req_s & ~req_d) : req_s;

    // Handshake: irq_valid=1 holds irq_idx stable until the consumer raises
    // irq_ack; the transfer completes on the rising edge where both are 1.
    // irq_ack with irq_valid=0 has no effect.
    assign clr_vec = (state_q == PRESENT && irq_ack) ? onehot8(idx_q) : '0;

    // Set is OR-ed after the clear so an event arriving with the ack survives.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending_q  <= '0;
            overflow_q <= '0;
        end else begin
            pending_q <= (pending_q & ~clr_vec) | set_vec;
            if (EDGE_MODE != 0) begin
                overflow_q <= (ovf_clr ? '0 : overflow_q) | (set_vec & pending_q & ~clr_vec);
            end else begin
                overflow_q <= '0;
            end
        end
    end

    assign eligible = pending_q & mask;

    prio_enc8 u_prio_enc8 (
        .eligible  (eligible),
        .index     (enc_idx),
        .any_valid (enc_any)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    // The index is frozen while presenting; new arrivals wait for the bubble.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        case (state_q)
            IDLE: begin
                if (enc_any) begin
                    idx_d   = enc_idx;
                    state_d = PRESENT;
                end
            end
            PRESENT: begin
                if (irq_ack) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign irq_valid = (state_q == PRESENT);
    assign irq_idx   = idx_q;
    assign pending   = pending_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_irq_req_capture.sv
// Directed bench for irq_req_capture with hand-computed expectations.
module tb_irq_req_capture;

    logic       clk;
    logic       rst;
    logic [7:0] req_in;
    logic [7:0] mask;
    logic       irq_ack;
    logic       ovf_clr;
    logic       irq_valid;
    logic [2:0] irq_idx;
    logic [7:0] pending;
    logic [7:0] overflow;

    int vec_count;
    int miscompares;

    irq_req_capture #(
        .EDGE_MODE   (1),
        .SYNC_STAGES (2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_in    (req_in),
        .mask      (mask),
        .irq_ack   (irq_ack),
        .ovf_clr   (ovf_clr),
        .irq_valid (irq_valid),
        .irq_idx   (irq_idx),
        .pending   (pending),
        .overflow  (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vec_count++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %02h expected %02h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge, then settle 1ns past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Hold req_in for three sampling edges k..k+2; pending is set after k+2.
    task automatic pulse_req(input logic [7:0] val);
        req_in = val;
        ticks(3);
        req_in = 8'h00;
    endtask

    task automatic do_ack();
        irq_ack = 1'b1;
        tick();
        irq_ack = 1'b0;
    endtask

    initial begin
        vec_count   = 0;
        miscompares = 0;
        rst     = 1'b1;
        req_in  = 8'h00;
        mask    = 8'hFF;
        irq_ack = 1'b0;
        ovf_clr = 1'b0;
        #1;
        check("rst_valid", {7'd0, irq_valid}, 8'h00);
        check("rst_idx", {5'd0, irq_idx}, 8'h00);
        check("rst_pending", pending, 8'h00);
        check("rst_overflow", overflow, 8'h00);
        ticks(2);
        rst = 1'b0;
        ticks(2);

        // 1: single request, latency and ack
        req_in = 8'h20;
        tick();
        check("t1_k_valid", {7'd0, irq_valid}, 8'h00);
        tick();
        check("t1_k1_pending", pending, 8'h00);
        tick();
        req_in = 8'h00;
        check("t1_k2_pending", pending, 8'h20);
        check("t1_k2_valid", {7'd0, irq_valid}, 8'h00);
        tick();
        check("t1_k3_valid", {7'd0, irq_valid}, 8'h01);
        check("t1_k3_idx", {5'd0, irq_idx}, 8'h05);
        do_ack();
        check("t1_ack_valid", {7'd0, irq_valid}, 8'h00);
        check("t1_ack_pending", pending, 8'h00);
        do_ack();
        check("t1_idle_ack_valid", {7'd0, irq_valid}, 8'h00);

        // 2: simultaneous bits 7 and 0
        pulse_req(8'h81);
        check("t2_pending", pending, 8'h81);
        tick();
        check("t2_first_valid", {7'd0, irq_valid}, 8'h01);
        check("t2_first_idx", {5'd0, irq_idx}, 8'h07);
        do_ack();
        check("t2_bubble_valid", {7'd0, irq_valid}, 8'h00);
        check("t2_bubble_pending", pending, 8'h01);
        tick();
        check("t2_second_valid", {7'd0, irq_valid}, 8'h01);
        check("t2_second_idx", {5'd0, irq_idx}, 8'h00);
        do_ack();
        check("t2_end_pending", pending, 8'h00);

        // 3: masked high-priority bit
        mask = 8'h7F;
        pulse_req(8'h84);
        tick();
        check("t3_masked_idx", {5'd0, irq_idx}, 8'h02);
        check("t3_masked_valid", {7'd0, irq_valid}, 8'h01);
        do_ack();
        check("t3_pending", pending, 8'h80);
        tick();
        check("t3_held_valid", {7'd0, irq_valid}, 8'h00);
        mask = 8'hFF;
        tick();
        check("t3_unmask_valid", {7'd0, irq_valid}, 8'h01);
        check("t3_unmask_idx", {5'd0, irq_idx}, 8'h07);
        do_ack();
        check("t3_end_pending", pending, 8'h00);

        // 4: overflow on a second edge before ack
        pulse_req(8'h08);
        tick();
        check("t4_first_idx", {5'd0, irq_idx}, 8'h03);
        pulse_req(8'h08);
        check("t4_overflow", overflow, 8'h08);
        check("t4_pending", pending, 8'h08);
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        check("t4_ovf_cleared", overflow, 8'h00);
        check("t4_still_valid", {7'd0, irq_valid}, 8'h01);
        check("t4_still_idx", {5'd0, irq_idx}, 8'h03);
        do_ack();
        check("t4_end_pending", pending, 8'h00);

        // 5: new edge coincident with ack wins over the clear
        pulse_req(8'h10);
        tick();
        check("t5_idx", {5'd0, irq_idx}, 8'h04);
        req_in = 8'h10;
        ticks(2);
        irq_ack = 1'b1;
        tick();
        irq_ack = 1'b0;
        req_in  = 8'h00;
        check("t5_ack_valid", {7'd0, irq_valid}, 8'h00);
        check("t5_ack_pending", pending, 8'h10);
        check("t5_no_overflow", overflow, 8'h00);
        tick();
        check("t5_again_valid", {7'd0, irq_valid}, 8'h01);
        check("t5_again_idx", {5'd0, irq_idx}, 8'h04);
        do_ack();
        check("t5_end_pending", pending, 8'h00);

        // 6: asynchronous reset while presenting
        pulse_req(8'h0C);
        tick();
        check("t6_pre_pending", pending, 8'h0C);
        check("t6_pre_idx", {5'd0, irq_idx}, 8'h03);
        #2;
        rst    = 1'b1;
        req_in = 8'h01;
        #1;
        check("t6_async_valid", {7'd0, irq_valid}, 8'h00);
        check("t6_async_pending", pending, 8'h00);
        check("t6_async_overflow", overflow, 8'h00);
        ticks(2);
        rst = 1'b0;
        ticks(3);
        check("t6_rel_pending", pending, 8'h01);
        tick();
        check("t6_rel_valid", {7'd0, irq_valid}, 8'h01);
        check("t6_rel_idx", {5'd0, irq_idx}, 8'h00);
        do_ack();
        check("t6_end_pending", pending, 8'h00);
        req_in = 8'h00;
        ticks(4);
        check("t6_quiet_valid", {7'd0, irq_valid}, 8'h00);

        $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompares);
        $finish;
    end

endmodule
